hack_data_memory: RTL and testbench

Data-memory responder for the Hack CPU: it serves the CPU's `adrr`/`outm`/`writm` data port and returns `inpm` within the same cycle. It holds a 16K-word RAM and an 8K-word memory-mapped screen buffer, plus a keyboard input queue fed by a valid/ready handshake. A registered second read port lets a video scanner read the screen buffer without stalling the CPU.

---
 rtl/hack_mem_pkg.sv | 36 +++
 rtl/hack_data_memory_kbd_fifo.sv | 97 +++++++++
 rtl/hack_data_memory.sv | 83 ++++++++
 tb/tb_hack_data_memory.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared constants and address-region decode for the Hack data-memory responder.
// Regions: RAM, screen buffer, keyboard register; everything else is unmapped.
package hack_mem_pkg;

    localparam int WORD_W    = 16;
    localparam int RAM_WORDS = 16384;
    localparam int SCR_WORDS = 8192;

    localparam logic [14:0] RAM_BASE = 15'h0000;
    localparam logic [14:0] SCR_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR = 15'h6000;
    // Last decoded address; anything above reads as zero and ignores writes.
    localparam logic [14:0] MAP_TOP  = 15'h6000;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_SCR  = 2'd1,
        RGN_KBD  = 2'd2,
        RGN_NONE = 2'd3
    } region_e;

    function automatic region_e decode_region(input logic [14:0] a);
        region_e r;
        if (a > MAP_TOP) begin
            r = RGN_NONE;
        end else if (a == KBD_ADDR) begin
            r = RGN_KBD;
        end else if ((a - RAM_BASE) < (SCR_BASE - RAM_BASE)) begin
            r = RGN_RAM;
        end else begin
            r = RGN_SCR;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_data_memory_kbd_fifo.sv
// Keyboard keycode queue. With HACK_DATA_MEMORY_KBD_FIFO_EN defined it is a DEPTH-entry
// FIFO; otherwise a single holding register with a valid bit.
module kbd_fifo
    import hack_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic              empty,
    output logic              full,
    output logic [WORD_W-1:0] head
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("kbd_fifo: DEPTH must be a power of two and at least 2");
    end

`ifdef HACK_DATA_MEMORY_KBD_FIFO_EN
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_fire, pop_fire;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        push_fire = push && !full;
        // A pop against an empty queue is dropped even if a push lands this edge.
        pop_fire  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire && !reset) mem_q[wr_ptr_q] <= push_data;
    end
`else
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              valid_q, valid_d;
    logic              push_fire, pop_fire;

    always_comb begin
        empty     = !valid_q;
        full      = valid_q;
        push_fire = push && !valid_q;
        pop_fire  = pop && valid_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        if (pop_fire) valid_d = 1'b0;
        if (push_fire) begin
            valid_d = 1'b1;
            hold_d  = push_data;
        end
        head = valid_q ? hold_q : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data memory: RAM, screen buffer with registered scanner port, keyboard queue.
// Keyboard queue depth is selected by HACK_DATA_MEMORY_KBD_FIFO_EN (see kbd_fifo).
module hack_data_memory
    import hack_mem_pkg::*;
#(
    parameter int KBD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       adrr,
    input  logic [WORD_W-1:0] outm,
    input  logic              writm,
    output logic [WORD_W-1:0] inpm,
    input  logic [WORD_W-1:0] kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    input  logic [12:0]       scr_addr,
    output logic [WORD_W-1:0] scr_data
);

    logic [WORD_W-1:0] ram_q [RAM_WORDS];
    logic [WORD_W-1:0] scr_q [SCR_WORDS];
    logic [WORD_W-1:0] scr_data_q, scr_data_d;
    logic [WORD_W-1:0] kbd_head;
    logic [14:0]       addr;
    logic              unused_adrr_msb;
    logic              kbd_empty, kbd_full;
    logic              ram_we, scr_we, kbd_pop;
    region_e           rgn;

    assign addr            = adrr[14:0];
    assign unused_adrr_msb = adrr[15];
    assign rgn             = decode_region(addr);

    // Array writes are held off during reset; the arrays themselves are never cleared.
    assign ram_we  = writm && !reset && (rgn == RGN_RAM);
    assign scr_we  = writm && !reset && (rgn == RGN_SCR);
    assign kbd_pop = writm && (rgn == RGN_KBD);

    kbd_fifo #(
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (kbd_valid),
        .push_data (kbd_data),
        .pop       (kbd_pop),
        .empty     (kbd_empty),
        .full      (kbd_full),
        .head      (kbd_head)
    );

    assign kbd_ready = !kbd_full;

    always_comb begin
        inpm = '0;
        case (rgn)
            RGN_RAM: inpm = ram_q[addr[13:0]];
            RGN_SCR: inpm = scr_q[addr[12:0]];
            RGN_KBD: inpm = kbd_empty ? '0 : kbd_head;
            default: inpm = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[addr[13:0]] <= outm;
    end

    always_ff @(posedge clk) begin
        if (scr_we) scr_q[addr[12:0]] <= outm;
    end

    // Sampled with the pre-edge array contents, so a same-word CPU write shows up one edge later.
    assign scr_data_d = scr_q[scr_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) scr_data_q <= '0;
        else       scr_data_q <= scr_data_d;
    end

    assign scr_data = scr_data_q;

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory; keyboard expectations come from a queue model
// whose capacity follows HACK_DATA_MEMORY_KBD_FIFO_EN.
module tb_hack_data_memory;

    localparam int KBD_DEPTH = 4;
`ifdef HACK_DATA_MEMORY_KBD_FIFO_EN
    localparam int CAP = KBD_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] adrr = '0;
    logic [15:0] outm = '0;
    logic        writm = 1'b0;
    logic [15:0] inpm;
    logic [15:0] kbd_data = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready;
    logic [12:0] scr_addr = '0;
    logic [15:0] scr_data;

    int tests  = 0;
    int failed = 0;
    logic [15:0] sb[$];

    hack_data_memory #(.KBD_DEPTH(KBD_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .adrr      (adrr),
        .outm      (outm),
        .writm     (writm),
        .inpm      (inpm),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    // One clock cycle of stimulus; kbd_ready and reads of 0x6000 are scored against the queue model.
    task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic w,
                         input logic kv, input logic [15:0] kd);
        logic        push_ok, pop_ok;
        logic        exp_rdy;
        logic [15:0] exp_head;
        adrr = a; outm = d; writm = w; kbd_valid = kv; kbd_data = kd;
        #1;
        exp_rdy = (sb.size() < CAP);
        tests++;
        if (kbd_ready !== exp_rdy) begin
            failed++;
            $display("FAIL kbd_ready: got %b expected %b (model count %0d)", kbd_ready, exp_rdy, sb.size());
        end
        if (a[14:0] == 15'h6000) begin
            exp_head = (sb.size() > 0) ? sb[0] : 16'h0000;
            tests++;
            if (inpm !== exp_head) begin
                failed++;
                $display("FAIL kbd_head: got %h expected %h", inpm, exp_head);
            end
        end
        push_ok = kv && (sb.size() < CAP);
        pop_ok  = w && (a[14:0] == 15'h6000) && (sb.size() > 0);
        @(posedge clk);
        if (pop_ok)  void'(sb.pop_front());
        if (push_ok) sb.push_back(kd);
        #1;
        writm = 1'b0; kbd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < CAP + 1; i++) cycle(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic test_reset();
        adrr = 16'h6000;
        #1;
        tests++;
        if (kbd_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b expected 1", kbd_ready); end
        tests++;
        if (inpm !== 16'h0000) begin failed++; $display("FAIL reset_kbd: got %h expected 0000", inpm); end
        tests++;
        if (scr_data !== 16'h0000) begin failed++; $display("FAIL reset_scr: got %h expected 0000", scr_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ram();
        logic [15:0] addrs [6] = '{16'h0005, 16'h0000, 16'h0001, 16'h3FFF, 16'h1234, 16'h2AAA};
        logic [15:0] vals  [6] = '{16'h1234, 16'hAAAA, 16'h0F0F, 16'hC3C3, 16'h8001, 16'h7E7E};
        for (int i = 0; i < 6; i++) cycle(addrs[i], vals[i], 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            adrr = addrs[i]; #1;
            tests++;
            if (inpm !== vals[i]) begin
                failed++;
                $display("FAIL ram_read[%h]: got %h expected %h", addrs[i], inpm, vals[i]);
            end
        end
        adrr = 16'h8005; #1;
        tests++;
        if (inpm !== 16'h1234) begin failed++; $display("FAIL ram_bit15: got %h expected 1234", inpm); end
        cycle(16'h6001, 16'h7777, 1'b1, 1'b0, 16'h0);
        cycle(16'h7FFF, 16'h6666, 1'b1, 1'b0, 16'h0);
        adrr = 16'h6001; #1;
        tests++;
        if (inpm !== 16'h0000) begin failed++; $display("FAIL unmapped_6001: got %h expected 0000", inpm); end
        adrr = 16'h7FFF; #1;
        tests++;
        if (inpm !== 16'h0000) begin failed++; $display("FAIL unmapped_7fff: got %h expected 0000", inpm); end
        adrr = 16'h0001; #1;
        tests++;
        if (inpm !== 16'h0F0F) begin failed++; $display("FAIL unmapped_alias: got %h expected 0f0f", inpm); end
    endtask

    task automatic test_screen();
        cycle(16'h4010, 16'h1111, 1'b1, 1'b0, 16'h0);
        scr_addr = 13'h0010;
        cycle(16'h4010, 16'hBEEF, 1'b1, 1'b0, 16'h0);
        tests++;
        if (scr_data !== 16'h1111) begin failed++; $display("FAIL scr_rbw: got %h expected 1111", scr_data); end
        cycle(16'h4010, 16'h0, 1'b0, 1'b0, 16'h0);
        tests++;
        if (scr_data !== 16'hBEEF) begin failed++; $display("FAIL scr_new: got %h expected beef", scr_data); end
        tests++;
        if (inpm !== 16'hBEEF) begin failed++; $display("FAIL scr_inpm: got %h expected beef", inpm); end
        cycle(16'h4000, 16'h5555, 1'b1, 1'b0, 16'h0);
        cycle(16'h5FFF, 16'h5A5A, 1'b1, 1'b0, 16'h0);
        scr_addr = 13'h1FFF;
        cycle(16'h0000, 16'h0, 1'b0, 1'b0, 16'h0);
        tests++;
        if (scr_data !== 16'h5A5A) begin failed++; $display("FAIL scr_top: got %h expected 5a5a", scr_data); end
        tests++;
        if (inpm !== 16'hAAAA) begin failed++; $display("FAIL ram_vs_scr: got %h expected aaaa", inpm); end
        adrr = 16'h4000; #1;
        tests++;
        if (inpm !== 16'h5555) begin failed++; $display("FAIL scr_base: got %h expected 5555", inpm); end
        scr_addr = 13'h0010;
        @(posedge clk); #1;
    endtask

    task automatic test_kbd_order();
        cycle(16'h0, 16'h0, 1'b0, 1'b1, 16'h0041);
        cycle(16'h0, 16'h0, 1'b0, 1'b1, 16'h0042);
        cycle(16'h0, 16'h0, 1'b0, 1'b1, 16'h0043);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
            cycle(16'h6000, 16'hFFFF, 1'b1, 1'b0, 16'h0);
        end
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_kbd_wrap();
        for (int i = 0; i < 2 * KBD_DEPTH + 2; i++) begin
            cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0100 + 16'(i));
            cycle(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
        end
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < CAP; i++) cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0050 + 16'(i));
        cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0099);
        cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0099);
        cycle(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
        while (sb.size() > 2) cycle(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
        while (sb.size() < 2 && sb.size() < CAP) cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0060);
        cycle(16'h6000, 16'h0, 1'b1, 1'b1, 16'h0061);
        cycle(16'h6000, 16'h0, 1'b1, 1'b1, 16'h0062);
        drain();
        cycle(16'h6000, 16'h0, 1'b1, 1'b1, 16'h0070);
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
        drain();
    endtask

    task automatic test_hold_stall();
        cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0041);
        for (int i = 0; i < 3; i++) cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0042);
        cycle(16'h6000, 16'h0, 1'b1, 1'b1, 16'h0042);
        cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0042);
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 120; i++) begin
            cycle(16'h6000, 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom));
        end
        drain();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0070 + 16'(i));
        tests++;
        if (scr_data !== 16'hBEEF) begin failed++; $display("FAIL pre_reset_scr: got %h expected beef", scr_data); end
        adrr = 16'h6000;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (kbd_ready !== 1'b1) begin failed++; $display("FAIL midreset_ready: got %b expected 1", kbd_ready); end
        tests++;
        if (inpm !== 16'h0000) begin failed++; $display("FAIL midreset_kbd: got %h expected 0000", inpm); end
        tests++;
        if (scr_data !== 16'h0000) begin failed++; $display("FAIL midreset_scr: got %h expected 0000", scr_data); end
        adrr = 16'h0005; outm = 16'hDEAD; writm = 1'b1; kbd_valid = 1'b1; kbd_data = 16'h0077;
        @(posedge clk); #1;
        tests++;
        if (scr_data !== 16'h0000) begin failed++; $display("FAIL reset_hold_scr: got %h expected 0000", scr_data); end
        writm = 1'b0; kbd_valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        #1;
        tests++;
        if (inpm !== 16'h1234) begin failed++; $display("FAIL reset_write_blocked: got %h expected 1234", inpm); end
        @(posedge clk); #1;
        tests++;
        if (scr_data !== 16'hBEEF) begin failed++; $display("FAIL post_reset_scr: got %h expected beef", scr_data); end
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
        cycle(16'h6000, 16'h0, 1'b0, 1'b1, 16'h0088);
        cycle(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
        cycle(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_ram();
        test_screen();
        test_kbd_order();
        test_kbd_wrap();
        test_full_simul();
        test_hold_stall();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
